pulse_ctrl: RTL and testbench

PULSE_CTRL -- requirements
Module: pulse_ctrl

---
 rtl/pulse_pkg.sv | 38 +++
 rtl/pulse_envelope.sv | 43 ++++
 rtl/pulse_ctrl.sv | 145 ++++++++++++++
 tb/tb_pulse_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse channel controller: register map,
// field positions inside the written byte, and the length-counter table.
package pulse_pkg;

    // Register addresses as seen on iWr_addr
    typedef enum logic [1:0] {
        ADDR_CTRL      = 2'd0,
        ADDR_SWEEP     = 2'd1,
        ADDR_PERIOD_LO = 2'd2,
        ADDR_PERIOD_HI = 2'd3
    } reg_addr_e;

    // Field positions in the control byte (addr0)
    localparam int DUTY_HI   = 7;
    localparam int DUTY_LO   = 6;
    localparam int HALT_BIT  = 5;
    localparam int CONST_BIT = 4;
    localparam int VOL_HI    = 3;
    localparam int VOL_LO    = 0;

    // Field positions in the length/period-high byte (addr3)
    localparam int LEN_IDX_HI = 7;
    localparam int LEN_IDX_LO = 3;
    localparam int PER_HI_HI  = 2;
    localparam int PER_HI_LO  = 0;

    // Width of the architectural period register (8 low bits + 3 high bits)
    localparam int PERIOD_W = 11;

    // Length counter load values, indexed by the 5-bit len_idx field
    localparam logic [7:0] LEN_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

endpackage

// File: rtl/pulse_envelope.sv
// Envelope generator: a divider clocked by quarter-frame pulses that steps a
// 4-bit decay level down from 15, optionally looping, or a constant volume.
module pulse_envelope
    import pulse_pkg::*;
(
    input  logic       clk,
    input  logic       iReset_n,
    input  logic       iQuarter_frame,
    input  logic       iStart,
    input  logic       iLoop,
    input  logic       iConst_vol,
    input  logic [3:0] iVol,
    output logic [3:0] oVolume
);

    logic [3:0] r_decay;
    logic [3:0] r_divider;

    // Divider and decay level advance only on quarter-frame pulses; a pending start restarts at full level
    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_decay   <= 4'd0;
            r_divider <= 4'd0;
        end else if (iQuarter_frame) begin
            if (iStart) begin
                r_decay   <= 4'd15;
                r_divider <= iVol;
            end else if (r_divider == 4'd0) begin
                r_divider <= iVol;
                if (r_decay != 4'd0) begin
                    r_decay <= r_decay - 4'd1;
                end else if (iLoop) begin
                    r_decay <= 4'd15;
                end
            end else begin
                r_divider <= r_divider - 4'd1;
            end
        end
    end

    assign oVolume = iConst_vol ? iVol : r_decay;

endmodule

// File: rtl/pulse_ctrl.sv
// Pulse channel control: register file, period timer producing sequencer
// step pulses, length counter with halt, and the envelope sub-block.
module pulse_ctrl
    import pulse_pkg::*;
#(
    parameter int TIMER_W    = 11,
    parameter int MIN_PERIOD = 8
) (
    input  logic       clk,
    input  logic       iReset_n,
    input  logic       iTick,
    input  logic       iQuarter_frame,
    input  logic       iHalf_frame,
    input  logic       iChan_en,
    input  logic       iWr_en,
    input  logic [1:0] iWr_addr,
    input  logic [7:0] iWr_data,
    output logic       oStep,
    output logic       oSeq_reset,
    output logic [1:0] oDuty_type,
    output logic       oGate,
    output logic [3:0] oVolume,
    output logic       oLen_active
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    logic [1:0]          r_duty;
    logic                r_halt;
    logic                r_constVol;
    logic [3:0]          r_vol;
    logic [PERIOD_W-1:0] r_period;
    logic                r_armed;
    logic [TIMER_W-1:0]  r_timer;
    logic                r_step;
    logic                r_seqReset;
    logic                r_start;
    logic [7:0]          r_lenCount;

    logic                w_wrCtrl;
    logic                w_wrPerLo;
    logic                w_wrPerHi;
    logic [PERIOD_W-1:0] w_newPeriod;
    logic [4:0]          w_lenIdx;

    assign w_wrCtrl    = iWr_en && (iWr_addr == ADDR_CTRL);
    assign w_wrPerLo   = iWr_en && (iWr_addr == ADDR_PERIOD_LO);
    assign w_wrPerHi   = iWr_en && (iWr_addr == ADDR_PERIOD_HI);
    assign w_newPeriod = {iWr_data[PER_HI_HI:PER_HI_LO], r_period[7:0]};
    assign w_lenIdx    = iWr_data[LEN_IDX_HI:LEN_IDX_LO];

    // Register file; the timer stays idle after reset until software writes a period byte
    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_duty     <= 2'd0;
            r_halt     <= 1'b0;
            r_constVol <= 1'b0;
            r_vol      <= 4'd0;
            r_period   <= '0;
            r_armed    <= 1'b0;
        end else begin
            if (w_wrCtrl) begin
                r_duty     <= iWr_data[DUTY_HI:DUTY_LO];
                r_halt     <= iWr_data[HALT_BIT];
                r_constVol <= iWr_data[CONST_BIT];
                r_vol      <= iWr_data[VOL_HI:VOL_LO];
            end
            if (w_wrPerLo) begin
                r_period[7:0] <= iWr_data;
            end
            if (w_wrPerHi) begin
                r_period[PERIOD_W-1:8] <= iWr_data[PER_HI_HI:PER_HI_LO];
            end
            if (w_wrPerLo || w_wrPerHi) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Period timer: counts down on ticked cycles and emits a one-cycle step when it wraps; a high-period write restarts it
    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_timer <= '0;
            r_step  <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (w_wrPerHi) begin
                r_timer <= TIMER_W'(w_newPeriod);
            end else if (r_armed && iTick) begin
                if (r_timer == '0) begin
                    r_timer <= TIMER_W'(r_period);
                    r_step  <= 1'b1;
                end else begin
                    r_timer <= r_timer - TIMER_W'(1);
                end
            end
        end
    end

    // A high-period write resets the duty phase and requests an envelope restart, which the next quarter frame consumes
    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_seqReset <= 1'b0;
            r_start    <= 1'b0;
        end else begin
            r_seqReset <= w_wrPerHi;
            if (w_wrPerHi) begin
                r_start <= 1'b1;
            end else if (iQuarter_frame) begin
                r_start <= 1'b0;
            end
        end
    end

    // Length counter: disabled channel forces zero, a load beats a same-cycle half-frame decrement, halt freezes it
    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_lenCount <= 8'd0;
        end else if (!iChan_en) begin
            r_lenCount <= 8'd0;
        end else if (w_wrPerHi) begin
            r_lenCount <= LEN_TABLE[w_lenIdx];
        end else if (iHalf_frame && !r_halt && (r_lenCount != 8'd0)) begin
            r_lenCount <= r_lenCount - 8'd1;
        end
    end

    pulse_envelope uEnvelope (
        .clk            (clk),
        .iReset_n       (iReset_n),
        .iQuarter_frame (iQuarter_frame),
        .iStart         (r_start),
        .iLoop          (r_halt),
        .iConst_vol     (r_constVol),
        .iVol           (r_vol),
        .oVolume        (oVolume)
    );

    assign oStep       = r_step;
    assign oSeq_reset  = r_seqReset;
    assign oDuty_type  = r_duty;
    assign oLen_active = (r_lenCount != 8'd0);
    assign oGate       = oLen_active && (r_period >= MIN_P);

endmodule

// File: tb/tb_pulse_ctrl.sv
// Directed testbench for pulse_ctrl with hand-computed expectations.
module tb_pulse_ctrl;

    logic       clk;
    logic       iReset_n;
    logic       iTick;
    logic       iQuarter_frame;
    logic       iHalf_frame;
    logic       iChan_en;
    logic       iWr_en;
    logic [1:0] iWr_addr;
    logic [7:0] iWr_data;
    logic       oStep;
    logic       oSeq_reset;
    logic [1:0] oDuty_type;
    logic       oGate;
    logic [3:0] oVolume;
    logic       oLen_active;

    int errCount   = 0;
    int checkCount = 0;

    pulse_ctrl #(.TIMER_W(11), .MIN_PERIOD(8)) dut (
        .clk            (clk),
        .iReset_n       (iReset_n),
        .iTick          (iTick),
        .iQuarter_frame (iQuarter_frame),
        .iHalf_frame    (iHalf_frame),
        .iChan_en       (iChan_en),
        .iWr_en         (iWr_en),
        .iWr_addr       (iWr_addr),
        .iWr_data       (iWr_data),
        .oStep          (oStep),
        .oSeq_reset     (oSeq_reset),
        .oDuty_type     (oDuty_type),
        .oGate          (oGate),
        .oVolume        (oVolume),
        .oLen_active    (oLen_active)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report it when observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One-cycle register write; returns 1 time unit after the capturing edge
    task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] data);
        iWr_en   = 1'b1;
        iWr_addr = addr;
        iWr_data = data;
        @(posedge clk); #1;
        iWr_en   = 1'b0;
    endtask

    task automatic halfPulse();
        iHalf_frame = 1'b1;
        @(posedge clk); #1;
        iHalf_frame = 1'b0;
    endtask

    task automatic quarterPulse();
        iQuarter_frame = 1'b1;
        @(posedge clk); #1;
        iQuarter_frame = 1'b0;
    endtask

    // Directed scenario sequence
    initial begin
        int stepCount;
        int firstStep;
        int lastStep;
        int gapBad;
        int k;
        int expVol;

        iReset_n       = 1'b0;
        iTick          = 1'b0;
        iQuarter_frame = 1'b0;
        iHalf_frame    = 1'b0;
        iChan_en       = 1'b0;
        iWr_en         = 1'b0;
        iWr_addr       = 2'd0;
        iWr_data       = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_step", oStep, 0);
        checkOutput("rst_seq_reset", oSeq_reset, 0);
        checkOutput("rst_duty", oDuty_type, 0);
        checkOutput("rst_gate", oGate, 0);
        checkOutput("rst_volume", oVolume, 0);
        checkOutput("rst_len_active", oLen_active, 0);
        iReset_n = 1'b1;
        iChan_en = 1'b1;
        @(posedge clk); #1;

        // Control register and ignored address
        applyStimulus(2'd0, 8'b10_0_1_0101);
        checkOutput("duty_write", oDuty_type, 2);
        checkOutput("const_volume", oVolume, 5);
        applyStimulus(2'd1, 8'hFF);
        checkOutput("addr1_ignored_duty", oDuty_type, 2);
        checkOutput("addr1_ignored_vol", oVolume, 5);

        // Timer: period 8 gives a step every 9 ticked cycles
        applyStimulus(2'd2, 8'd8);
        applyStimulus(2'd3, 8'h00);
        checkOutput("seq_reset_pulse", oSeq_reset, 1);
        checkOutput("len_loaded", oLen_active, 1);
        checkOutput("gate_period8", oGate, 1);
        iTick = 1'b1;
        stepCount = 0; firstStep = 0; lastStep = 0; gapBad = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (i == 1) checkOutput("seq_reset_one_cycle", oSeq_reset, 0);
            if (oStep) begin
                if (stepCount == 0) firstStep = i;
                else if (i - lastStep != 9) gapBad++;
                lastStep = i;
                stepCount++;
            end
        end
        iTick = 1'b0;
        checkOutput("step_first", firstStep, 9);
        checkOutput("step_gap_errors", gapBad, 0);
        checkOutput("step_count", stepCount, 3);

        // Mute threshold
        applyStimulus(2'd2, 8'd7);
        checkOutput("gate_period7_muted", oGate, 0);
        applyStimulus(2'd2, 8'd8);
        checkOutput("gate_period8_open", oGate, 1);

        // Length counter: idx0 = 10 half frames
        applyStimulus(2'd3, 8'h00);
        repeat (9) halfPulse();
        checkOutput("len_after_9", oLen_active, 1);
        halfPulse();
        checkOutput("len_after_10", oLen_active, 0);
        checkOutput("gate_len_zero", oGate, 0);
        halfPulse();
        checkOutput("len_saturate", oLen_active, 0);

        // Halt freezes the counter
        applyStimulus(2'd0, 8'h20);
        applyStimulus(2'd3, 8'h00);
        repeat (12) halfPulse();
        checkOutput("len_halted", oLen_active, 1);
        applyStimulus(2'd0, 8'h00);

        // Load beats simultaneous half frame: 5 -> 254, not 4
        applyStimulus(2'd3, 8'h00);
        repeat (5) halfPulse();
        iHalf_frame = 1'b1;
        applyStimulus(2'd3, 8'h08);
        iHalf_frame = 1'b0;
        repeat (4) halfPulse();
        checkOutput("simul_after_4", oLen_active, 1);
        repeat (249) halfPulse();
        checkOutput("simul_after_253", oLen_active, 1);
        halfPulse();
        checkOutput("simul_after_254", oLen_active, 0);

        // Channel disable clears and blocks loads
        applyStimulus(2'd3, 8'h00);
        checkOutput("chan_loaded", oLen_active, 1);
        iChan_en = 1'b0;
        @(posedge clk); #1;
        checkOutput("chan_off_clears", oLen_active, 0);
        applyStimulus(2'd3, 8'h00);
        checkOutput("chan_off_blocks_load", oLen_active, 0);
        iChan_en = 1'b1;

        // Envelope, no loop: 15 after first pulse, down one every 2 pulses, holds at 0
        applyStimulus(2'd0, 8'h01);
        applyStimulus(2'd3, 8'h00);
        for (int n = 1; n <= 34; n++) begin
            quarterPulse();
            k = (n - 1) / 2;
            expVol = (k > 15) ? 0 : 15 - k;
            checkOutput($sformatf("env_noloop_%0d", n), oVolume, expVol);
        end

        // Envelope with loop: wraps back to 15 after reaching 0
        applyStimulus(2'd0, 8'h21);
        applyStimulus(2'd3, 8'h00);
        for (int n = 1; n <= 34; n++) begin
            quarterPulse();
            k = (n - 1) / 2;
            expVol = 15 - (k % 16);
            checkOutput($sformatf("env_loop_%0d", n), oVolume, expVol);
        end

        // Constant volume overrides decay
        applyStimulus(2'd0, 8'h1A);
        checkOutput("const_vol_10", oVolume, 10);

        // Asynchronous reset between edges, mid-count
        applyStimulus(2'd0, 8'hD7);
        applyStimulus(2'd2, 8'd8);
        applyStimulus(2'd3, 8'h00);
        iTick = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("pre_rst_duty", oDuty_type, 3);
        checkOutput("pre_rst_volume", oVolume, 7);
        #2;
        iReset_n = 1'b0;
        #1;
        checkOutput("async_rst_step", oStep, 0);
        checkOutput("async_rst_seq_reset", oSeq_reset, 0);
        checkOutput("async_rst_duty", oDuty_type, 0);
        checkOutput("async_rst_gate", oGate, 0);
        checkOutput("async_rst_volume", oVolume, 0);
        checkOutput("async_rst_len", oLen_active, 0);
        @(posedge clk); #1;
        iReset_n = 1'b1;
        stepCount = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (oStep) stepCount++;
        end
        checkOutput("no_step_after_reset", stepCount, 0);
        applyStimulus(2'd2, 8'd3);
        firstStep = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (oStep && firstStep == 0) firstStep = i;
        end
        checkOutput("step_after_period_write", firstStep, 1);

        // Period 0 steps on every ticked cycle
        applyStimulus(2'd2, 8'd0);
        applyStimulus(2'd3, 8'h00);
        stepCount = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (oStep) stepCount++;
        end
        checkOutput("period0_every_tick", stepCount, 5);
        iTick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("no_step_without_tick", oStep, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
